// File: rtl/lsu_dtcm_agu.sv
// LSU front-end for the DTCM: checks alignment and builds the byte-lane command.
// It also sign/zero-extends load data and returns one writeback result per op.
module lsu_dtcm_agu #(
  parameter int ADDR_W = 16,
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu2lsu_valid,
  output logic              exu2lsu_ready,
  input  logic              exu2lsu_load,
  input  logic [2:0]        exu2lsu_funct3,
  input  logic [ADDR_W-1:0] exu2lsu_addr,
  input  logic [DW-1:0]     exu2lsu_wdata,
  input  logic [RD_W-1:0]   exu2lsu_rd,
  output logic              lsu2dtcm_cmd_valid,
  input  logic              lsu2dtcm_cmd_ready,
  output logic              lsu2dtcm_cmd_read,
  output logic [ADDR_W-1:0] lsu2dtcm_cmd_addr,
  output logic [MW-1:0]     lsu2dtcm_cmd_wmask,
  output logic [DW-1:0]     lsu2dtcm_cmd_wdata,
  input  logic              lsu2dtcm_rsp_valid,
  output logic              lsu2dtcm_rsp_ready,
  input  logic [DW-1:0]     lsu2dtcm_rsp_rdata,
  output logic              lsu2wb_valid,
  input  logic              lsu2wb_ready,
  output logic              lsu2wb_wen,
  output logic [RD_W-1:0]   lsu2wb_rd,
  output logic [DW-1:0]     lsu2wb_wdata,
  output logic              lsu2wb_err
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, WB} state_t;
  state_t state;

  logic              ld_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_W-1:0]   rd_q;
  logic [MW-1:0]     wmask_q;
  logic [DW-1:0]     lanes_q;
  logic              wb_wen_q;
  logic              wb_err_q;
  logic [DW-1:0]     wb_wdata_q;

  logic          in_legal;
  logic          in_misal;
  logic          in_bad;
  logic [MW-1:0] in_wmask;
  logic [DW-1:0] in_lanes;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ld_ext;

  // Lane placement is done at accept time so the command fields are plain registers.
  always_comb begin
    in_legal = 1'b0;
    case (exu2lsu_funct3)
      3'b000, 3'b001, 3'b010: in_legal = 1'b1;
      3'b100, 3'b101:         in_legal = exu2lsu_load;
      default:                in_legal = 1'b0;
    endcase
    in_misal = ((exu2lsu_funct3[1:0] == 2'b01) && exu2lsu_addr[0]) ||
               ((exu2lsu_funct3[1:0] == 2'b10) && (exu2lsu_addr[1:0] != 2'b00));
    in_bad   = !in_legal || in_misal;

    in_wmask = '0;
    in_lanes = '0;
    if (!exu2lsu_load) begin
      case (exu2lsu_funct3[1:0])
        2'b00: begin
          in_wmask = MW'(4'b0001) << exu2lsu_addr[1:0];
          in_lanes = {4{exu2lsu_wdata[7:0]}};
        end
        2'b01: begin
          in_wmask = MW'(4'b0011) << exu2lsu_addr[1:0];
          in_lanes = {2{exu2lsu_wdata[15:0]}};
        end
        default: begin
          in_wmask = '1;
          in_lanes = exu2lsu_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = lsu2dtcm_rsp_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{(DW-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{(DW-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {{(DW-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_ext = {{(DW-16){1'b0}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      rd_q       <= '0;
      wmask_q    <= '0;
      lanes_q    <= '0;
      wb_wen_q   <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (exu2lsu_valid) begin
          ld_q    <= exu2lsu_load;
          f3_q    <= exu2lsu_funct3;
          addr_q  <= exu2lsu_addr;
          rd_q    <= exu2lsu_rd;
          wmask_q <= in_wmask;
          lanes_q <= in_lanes;
          if (in_bad) begin
            wb_wen_q   <= 1'b0;
            wb_err_q   <= 1'b1;
            wb_wdata_q <= '0;
            state      <= WB;
          end else begin
            state <= CMD;
          end
        end
        CMD: if (lsu2dtcm_cmd_ready) state <= RSP;
        RSP: if (lsu2dtcm_rsp_valid) begin
          wb_wen_q   <= ld_q;
          wb_err_q   <= 1'b0;
          wb_wdata_q <= ld_q ? ld_ext : '0;
          state      <= WB;
        end
        WB: if (lsu2wb_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign exu2lsu_ready      = (state == IDLE);
  assign lsu2dtcm_cmd_valid = (state == CMD);
  assign lsu2dtcm_rsp_ready = (state == RSP);
  assign lsu2wb_valid       = (state == WB);
  assign lsu2dtcm_cmd_read  = ld_q;
  assign lsu2dtcm_cmd_addr  = addr_q;
  assign lsu2dtcm_cmd_wmask = wmask_q;
  assign lsu2dtcm_cmd_wdata = lanes_q;
  assign lsu2wb_wen         = wb_wen_q;
  assign lsu2wb_rd          = rd_q;
  assign lsu2wb_wdata       = wb_wdata_q;
  assign lsu2wb_err         = wb_err_q;

endmodule

// File: tb/tb_lsu_dtcm_agu.sv
// Scoreboard bench for lsu_dtcm_agu: expected command/writeback pushed when an op is
// driven, popped and compared at the DTCM and writeback handshakes.
module tb_lsu_dtcm_agu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exu_valid = 1'b0, exu_ready, exu_load = 1'b0;
  logic [2:0]  exu_f3 = '0;
  logic [15:0] exu_addr = '0;
  logic [31:0] exu_wdata = '0;
  logic [4:0]  exu_rd = '0;
  logic        cmd_valid, cmd_ready = 1'b0, cmd_read;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_wmask;
  logic [31:0] cmd_wdata;
  logic        rsp_valid = 1'b0, rsp_ready;
  logic [31:0] rsp_rdata = '0;
  logic        wb_valid, wb_ready = 1'b0, wb_wen, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;

  always #5 clk = ~clk;

  lsu_dtcm_agu #(.ADDR_W(16), .DW(32), .MW(4), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu2lsu_valid(exu_valid), .exu2lsu_ready(exu_ready), .exu2lsu_load(exu_load),
    .exu2lsu_funct3(exu_f3), .exu2lsu_addr(exu_addr), .exu2lsu_wdata(exu_wdata),
    .exu2lsu_rd(exu_rd),
    .lsu2dtcm_cmd_valid(cmd_valid), .lsu2dtcm_cmd_ready(cmd_ready),
    .lsu2dtcm_cmd_read(cmd_read), .lsu2dtcm_cmd_addr(cmd_addr),
    .lsu2dtcm_cmd_wmask(cmd_wmask), .lsu2dtcm_cmd_wdata(cmd_wdata),
    .lsu2dtcm_rsp_valid(rsp_valid), .lsu2dtcm_rsp_ready(rsp_ready),
    .lsu2dtcm_rsp_rdata(rsp_rdata),
    .lsu2wb_valid(wb_valid), .lsu2wb_ready(wb_ready), .lsu2wb_wen(wb_wen),
    .lsu2wb_rd(wb_rd), .lsu2wb_wdata(wb_wdata), .lsu2wb_err(wb_err)
  );

  typedef struct packed {
    logic        read;
    logic [15:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        err;
  } wb_t;

  cmd_t cmd_q[$];
  wb_t  wb_q[$];
  int n_vec = 0, n_bad = 0;
  int cmd_hs = 0, cmd_cyc = 0, wb_hs = 0;

  always @(posedge clk) begin
    if (cmd_valid) cmd_cyc++;
    if (cmd_valid && cmd_ready) cmd_hs++;
    if (wb_valid && wb_ready) wb_hs++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic op_bad(input logic ld, input logic [2:0] f3, input logic [15:0] a);
    logic legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (ld && (f3 == 3'd4 || f3 == 3'd5));
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic cmd_t exp_cmd(input logic ld, input logic [2:0] f3, input logic [15:0] a,
                                   input logic [31:0] wd);
    cmd_t c;
    c.read  = ld;
    c.addr  = a;
    c.wmask = 4'b0000;
    c.wdata = 32'h0;
    if (!ld) begin
      case (f3)
        3'd0: begin c.wmask = 4'b0001 << a[1:0]; c.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
        3'd1: begin c.wmask = 4'b0011 << a[1:0]; c.wdata = {wd[15:0], wd[15:0]}; end
        default: begin c.wmask = 4'b1111; c.wdata = wd; end
      endcase
    end
    return c;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> (8 * off);
    case (f3)
      3'd0: return {{24{s[7]}}, s[7:0]};
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd4: return {24'h0, s[7:0]};
      3'd5: return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  task automatic chk_cmd(input string tag, input cmd_t e);
    check({tag, ".cmd_read"}, {31'h0, cmd_read}, {31'h0, e.read});
    check({tag, ".cmd_addr"}, {16'h0, cmd_addr}, {16'h0, e.addr});
    check({tag, ".cmd_wmask"}, {28'h0, cmd_wmask}, {28'h0, e.wmask});
    if (!e.read) check({tag, ".cmd_wdata"}, cmd_wdata, e.wdata);
  endtask

  task automatic chk_wb(input string tag, input wb_t e);
    check({tag, ".wb_wen"}, {31'h0, wb_wen}, {31'h0, e.wen});
    check({tag, ".wb_rd"}, {27'h0, wb_rd}, {27'h0, e.rd});
    check({tag, ".wb_wdata"}, wb_wdata, e.wdata);
    check({tag, ".wb_err"}, {31'h0, wb_err}, {31'h0, e.err});
  endtask

  // One complete op; waits are counts of stall cycles applied by the bench.
  task automatic run_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [15:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int cmd_wait, input int rsp_wait,
                        input int wb_wait);
    logic bad;
    wb_t  w;
    cmd_t c;
    int   hs0, cyc0, wbh0;
    bad = op_bad(ld, f3, a);
    w.err   = bad;
    w.wen   = ld && !bad;
    w.rd    = rd;
    w.wdata = (ld && !bad) ? exp_load(f3, a[1:0], rdata) : 32'h0;
    wb_q.push_back(w);
    if (!bad) cmd_q.push_back(exp_cmd(ld, f3, a, wd));
    hs0 = cmd_hs; cyc0 = cmd_cyc; wbh0 = wb_hs;

    check({tag, ".exu_ready"}, {31'h0, exu_ready}, 32'd1);
    exu_valid = 1'b1; exu_load = ld; exu_f3 = f3; exu_addr = a; exu_wdata = wd; exu_rd = rd;
    step();
    exu_valid = 1'b0; exu_wdata = $urandom; exu_addr = 16'($urandom);
    check({tag, ".busy"}, {31'h0, exu_ready}, 32'd0);

    if (bad) begin
      check({tag, ".err_cmd_valid"}, {31'h0, cmd_valid}, 32'd0);
    end else begin
      for (int i = 0; i < cmd_wait; i++) begin
        cmd_ready = 1'b0;
        check({tag, ".cmd_valid_hold"}, {31'h0, cmd_valid}, 32'd1);
        chk_cmd({tag, ".stall"}, cmd_q[0]);
        check({tag, ".exu_ready_hold"}, {31'h0, exu_ready}, 32'd0);
        step();
      end
      cmd_ready = 1'b1;
      check({tag, ".cmd_valid"}, {31'h0, cmd_valid}, 32'd1);
      c = cmd_q.pop_front();
      chk_cmd(tag, c);
      step();
      cmd_ready = 1'b0;
      for (int i = 0; i < rsp_wait; i++) begin
        check({tag, ".rsp_wait"}, {31'h0, rsp_ready, wb_valid}, 32'd2);
        step();
      end
      check({tag, ".rsp_ready"}, {31'h0, rsp_ready}, 32'd1);
      rsp_valid = 1'b1; rsp_rdata = rdata;
      step();
      rsp_valid = 1'b0; rsp_rdata = $urandom;
    end

    for (int i = 0; i < wb_wait; i++) begin
      check({tag, ".wb_valid_hold"}, {31'h0, wb_valid}, 32'd1);
      chk_wb({tag, ".stall"}, wb_q[0]);
      check({tag, ".exu_ready_wb"}, {31'h0, exu_ready}, 32'd0);
      step();
    end
    wb_ready = 1'b1;
    check({tag, ".wb_valid"}, {31'h0, wb_valid}, 32'd1);
    w = wb_q.pop_front();
    chk_wb(tag, w);
    step();
    wb_ready = 1'b0;
    check({tag, ".idle"}, {31'h0, exu_ready}, 32'd1);
    check({tag, ".cmd_hs"}, 32'(cmd_hs - hs0), bad ? 32'd0 : 32'd1);
    check({tag, ".wb_hs"}, 32'(wb_hs - wbh0), 32'd1);
    if (bad) check({tag, ".cmd_cycles"}, 32'(cmd_cyc - cyc0), 32'd0);
  endtask

  initial begin
    step();
    step();
    check("rst.exu_ready", {31'h0, exu_ready}, 32'd1);
    check("rst.valids", {29'h0, cmd_valid, rsp_ready, wb_valid}, 32'd0);
    check("rst.wb_fields", {wb_wen, wb_err, wb_rd, wb_wdata[24:0]}, 32'd0);
    check("rst.cmd_fields", {cmd_read, cmd_addr, cmd_wmask, 11'h0}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("sw",   1'b0, 3'b010, 16'h0010, 32'hDEADBEEF, 5'd3,  32'h0,        0, 0, 0);
    run_op("sb",   1'b0, 3'b000, 16'h0013, 32'h000000A5, 5'd4,  32'h0,        0, 0, 0);
    run_op("lbu",  1'b1, 3'b100, 16'h0013, 32'h0,        5'd5,  32'hA5000000, 0, 0, 0);
    run_op("lb",   1'b1, 3'b000, 16'h0013, 32'h0,        5'd6,  32'hA5000000, 0, 0, 0);
    run_op("lh",   1'b1, 3'b001, 16'h0002, 32'h0,        5'd7,  32'h80017FFF, 0, 0, 0);
    run_op("lhu",  1'b1, 3'b101, 16'h0002, 32'h0,        5'd8,  32'h80017FFF, 0, 0, 0);
    run_op("lw_mis", 1'b1, 3'b010, 16'h0002, 32'h0,      5'd9,  32'h0,        0, 0, 0);
    run_op("ld011",  1'b1, 3'b011, 16'h0000, 32'h0,      5'd10, 32'h0,        0, 0, 0);
    run_op("st100",  1'b0, 3'b100, 16'h0000, 32'h1,      5'd11, 32'h0,        0, 0, 1);
    run_op("sh_mis", 1'b0, 3'b001, 16'h0101, 32'h1234,   5'd12, 32'h0,        0, 0, 0);
    run_op("lw",   1'b1, 3'b010, 16'hC004, 32'h0,        5'd13, 32'h12345678, 0, 0, 0);
    run_op("bp_sh", 1'b0, 3'b001, 16'h8006, 32'hFFFF1234, 5'd14, 32'h0,       3, 4, 2);
    run_op("bp_lb", 1'b1, 3'b000, 16'h0021, 32'h0,       5'd15, 32'h0000_8000, 3, 4, 2);

    for (int i = 0; i < 16; i++) begin
      run_op("rnd", 1'($urandom), 3'($urandom), 16'($urandom), $urandom, 5'($urandom),
             $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)));
    end

    begin : reset_mid_op
      int hs0, wbh0;
      exu_valid = 1'b1; exu_load = 1'b1; exu_f3 = 3'b010; exu_addr = 16'h0020; exu_rd = 5'd1;
      cmd_ready = 1'b1;
      step();
      exu_valid = 1'b0;
      step();
      cmd_ready = 1'b0;
      check("rstmid.in_rsp", {31'h0, rsp_ready}, 32'd1);
      hs0 = cmd_hs; wbh0 = wb_hs;
      rst_n = 1'b0;
      #1;
      check("rstmid.valids", {29'h0, cmd_valid, rsp_ready, wb_valid}, 32'd0);
      check("rstmid.exu_ready", {31'h0, exu_ready}, 32'd1);
      step();
      rst_n = 1'b1;
      rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D; wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check("rstmid.no_wb", {30'h0, wb_valid, cmd_valid}, 32'd0);
      end
      rsp_valid = 1'b0; wb_ready = 1'b0;
      check("rstmid.ready", {31'h0, exu_ready}, 32'd1);
      check("rstmid.hs", 32'((cmd_hs - hs0) + (wb_hs - wbh0)), 32'd0);
    end

    run_op("post", 1'b1, 3'b101, 16'h0042, 32'h0, 5'd2, 32'h7FFF_0000, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
